glift_rr_arbiter: RTL and testbench
===================================

# glift_rr_arbiter

Round-robin arbiter with gate-level information flow tracking (GLIFT) that shares one GLIFT-tracked datapath resource among N requesters. Every request carries a taint bit. The arbiter propagates taint conservatively into its grants and into its internal round-robin pointer. A trusted `taint_clr` pulse declassifies the pointer between tenures. It sits in front of the shared tracked-gate datapath and decides which requester drives it.

## Interface
- `N`, default 4: number of requesters, ≥2.
- `MAX_HOLD`, default 16: maximum tenure length in cycles, ≥2. The counter width is clog2(MAX_HOLD).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: request; must be held for the whole tenure.
- `req_t` input N: taint of each `req` bit.
- `taint_clr` input 1: trusted declassify pulse; honoured only in IDLE.
- `gnt` output N: one-hot grant, or all zero.
- `gnt_t` output N: grant taint; all bits are always equal.
- `busy` output 1: equals |gnt.
- `busy_t` output 1: equals gnt_t[0].

## Operation
- **State:**
  - FSM {IDLE, BUSY}
  - `ptr` (clog2 N)
  - `ptr_t`
  - `owner`
  - `own_t`
  - `cnt`
- **Reset:**
  - FSM=IDLE
  - `ptr`=0, `ptr_t`=0
  - `owner`=0, `own_t`=0
  - `cnt`=0
  - `gnt`=0, `gnt_t`=0, so `busy`=0 and `busy_t`=0
- **Effective pointer taint in IDLE:** `ept` = `taint_clr` ? 0 : `ptr_t`. In IDLE, `ptr_t` is updated to `ept` every cycle.
- **IDLE with |req=0:**
  - `gnt`<=0.
  - `gnt_t`<={N{|req_t}}. The absence of a grant depends on every request value.
- **IDLE with |req=1 (decision):**
  - `owner` = first i with req[i]=1, scanning circularly from `ptr` upward.
  - `gnt`<=onehot(owner).
  - `dec_t` = `ept` | (|req_t). All request taints count, because each can alter the winner.
  - `own_t`<=`dec_t`, `gnt_t`<={N{dec_t}}.
  - `cnt`<=0, FSM<=BUSY.
- **BUSY, per cycle:** let `ht` = `own_t` | req_t[owner].
  - **Voluntary release** (req[owner]=0):
    - `gnt`<=0, FSM<=IDLE.
    - `ptr`<=(owner+1) mod N, `ptr_t`<=`ht`.
    - `gnt_t`<={N{ht}}.
  - **Forced release** (req[owner]=1 and `cnt`=MAX_HOLD-1): same updates as voluntary release.
  - **Hold** (otherwise):
    - `gnt` unchanged.
    - `cnt`<=`cnt`+1.
    - `own_t`<=`ht`, `gnt_t`<={N{ht}}.
  - Requests and taints of non-owners are ignored in BUSY; they neither change the grant nor add taint.
- **`taint_clr` in BUSY:** ignored; `ptr_t` is unchanged.
- **Taint is sticky:** once `ptr_t`=1, every later decision is tainted until `taint_clr` is applied in IDLE.
- **`ptr` wrap:** owner N-1 releases to `ptr`=0.
- **Reset mid-tenure:** all state returns to reset values immediately and asynchronously. No release bookkeeping is performed.

## Timing
- **Grant latency:** `req` sampled high at edge k in IDLE gives `gnt` high after edge k. That is 1 cycle, and it is fully registered.
- **Release latency:** `req`[owner] sampled low at edge k gives `gnt` low after edge k.
- **Gap between tenures:** the next decision happens at edge k+1. There is a minimum of one IDLE cycle with `gnt`=0 between tenures.
- **Maximum tenure:** with `req` held continuously, `gnt` is high for exactly MAX_HOLD cycles. It then drops for ≥1 cycle.
- **Forced release and re-request:** if the forced-release owner still requests and is the only requester, it is regranted on the following decision. The pointer advance does not exclude it.
- **`taint_clr` on a decision edge:** `taint_clr` and a decision on the same edge means the decision already uses `ept`=0.
- **Output timing:** all outputs change only on `clk` edges or asynchronously on `rst_n` low.

## Test plan
- **Basic grant and release:** N=4, reset, req=4'b0100 with req_t=0 for 3 cycles, then 0.
  - `gnt`=0100 one cycle after `req` rises.
  - `gnt` drops one cycle after `req` falls.
  - `gnt_t`=0 throughout; `ptr`=3 afterwards.
- **Round-robin rotation:** req=4'b1111 held, MAX_HOLD=2.
  - Grants run in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 2 cycles, separated by 1 idle cycle.
- **Taint propagation:** req=4'b0011 with req_t=4'b0010. Requester 0 wins.
  - `gnt_t`=1111 and `busy_t`=1.
  - After release, `ptr_t`=1 and the next untainted decision still gives `gnt_t`=1111.
- **Declassification:** after the previous scenario, pulse `taint_clr` in IDLE with req=4'b0100 and req_t=0 on the same edge.
  - `gnt`=0100, `gnt_t`=0000.
  - A `taint_clr` pulse during BUSY leaves `ptr_t` unchanged.
- **Mid-tenure owner taint:** granted owner 1 clean; req_t[1]=1 for one cycle.
  - `gnt_t`=1111 from the following cycle and stays 1111 until release.
  - `ptr_t`=1 after release.
- **Asynchronous reset mid-tenure:** `rst_n` low while BUSY with `gnt`=1000 and `gnt_t`=1111.
  - `gnt`, `gnt_t`, `busy` and `busy_t` go to 0 without a clock edge.
  - After reset, req=4'b1001 grants 0001 (`ptr`=0).

Source files
------------

// File: rtl/glift_rr_arbiter_if.sv
// Request/grant bundle between requesters and the GLIFT round-robin arbiter.
// Every data bit travels with its taint bit.
interface glift_rr_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] req_t;
  logic         taint_clr;
  logic [N-1:0] gnt;
  logic [N-1:0] gnt_t;
  logic         busy;
  logic         busy_t;

  modport master (
    output req, req_t, taint_clr,
    input  gnt, gnt_t, busy, busy_t
  );

  modport slave (
    input  req, req_t, taint_clr,
    output gnt, gnt_t, busy, busy_t
  );
endinterface

// File: rtl/glift_rr_arbiter.sv
// Round-robin arbiter that tracks information flow (GLIFT) from requests into grants
// and into its rotation pointer. A trusted taint_clr declassifies the pointer while idle.
module glift_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst_n,
  glift_rr_arbiter_if.slave bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_n;
  logic [PW-1:0] ptr_q, ptr_n;
  logic          ptr_t_q, ptr_t_n;
  logic [PW-1:0] owner_q, owner_n;
  logic          own_t_q, own_t_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [N-1:0]  gnt_q, gnt_n;
  logic          gnt_t_q, gnt_t_n;
  logic          busy_q;

  logic [PW-1:0] win;
  logic          ept;
  logic          dec_t;
  logic          ht;

  // Circular scan for the first requester at or above the pointer.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr_q) + off) % N);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign ept   = bus.taint_clr ? 1'b0 : ptr_t_q;
  assign dec_t = ept | (|bus.req_t);
  assign ht    = own_t_q | bus.req_t[owner_q];

  // Next state, grants and taint propagation.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    ptr_t_n = ptr_t_q;
    owner_n = owner_q;
    own_t_n = own_t_q;
    cnt_n   = cnt_q;
    gnt_n   = gnt_q;
    gnt_t_n = gnt_t_q;
    unique case (state_q)
      IDLE: begin
        ptr_t_n = ept;
        if (|bus.req) begin
          owner_n = win;
          gnt_n   = N'(1) << win;
          own_t_n = dec_t;
          gnt_t_n = dec_t;
          cnt_n   = '0;
          state_n = BUSY;
        end else begin
          // The absence of a grant depends on every request bit.
          gnt_n   = '0;
          gnt_t_n = |bus.req_t;
        end
      end
      BUSY: begin
        if (!bus.req[owner_q] || (cnt_q == CW'(MAX_HOLD - 1))) begin
          gnt_n   = '0;
          state_n = IDLE;
          ptr_n   = PW'((32'(owner_q) + 32'd1) % N);
          ptr_t_n = ht;
          gnt_t_n = ht;
        end else begin
          cnt_n   = cnt_q + CW'(1);
          own_t_n = ht;
          gnt_t_n = ht;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ptr_t_q <= 1'b0;
      owner_q <= '0;
      own_t_q <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gnt_t_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      ptr_t_q <= ptr_t_n;
      owner_q <= owner_n;
      own_t_q <= own_t_n;
      cnt_q   <= cnt_n;
      gnt_q   <= gnt_n;
      gnt_t_q <= gnt_t_n;
      busy_q  <= |gnt_n;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_t  = {N{gnt_t_q}};
  assign bus.busy   = busy_q;
  assign bus.busy_t = gnt_t_q;
endmodule

// File: tb/tb_glift_rr_arbiter.sv
// Directed bench for glift_rr_arbiter: one instance with default tenure, one with MAX_HOLD=2.
module tb_glift_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  glift_rr_arbiter_if #(.N(4)) ifa ();
  glift_rr_arbiter_if #(.N(4)) ifb ();

  glift_rr_arbiter #(.N(4), .MAX_HOLD(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  glift_rr_arbiter #(.N(4), .MAX_HOLD(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs and samples sit 1ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [3:0] r, input logic [3:0] rt, input logic clr);
    ifa.req       = r;
    ifa.req_t     = rt;
    ifa.taint_clr = clr;
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({ifa.gnt, ifa.gnt_t, ifa.busy, ifa.busy_t});
  endfunction

  logic [3:0] rot_exp [13];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drv_a(4'b0000, 4'b0000, 1'b0);
    ifb.req       = '0;
    ifb.req_t     = '0;
    ifb.taint_clr = 1'b0;
    rot_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    step(2);
    check("reset_outs_a", outs_a(), 32'h0);
    check("reset_busy_b", 32'({ifb.gnt, ifb.busy}), 32'h0);
    rst_n = 1'b1;

    // Rotation with MAX_HOLD=2 and all four requesting.
    ifb.req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      step(1);
      check($sformatf("rot_gnt_%0d", i), 32'(ifb.gnt), 32'(rot_exp[i]));
    end
    check("rot_gnt_t", 32'(ifb.gnt_t), 32'h0);
    ifb.req = 4'b0000;

    // Basic grant/release on requester 2.
    drv_a(4'b0100, 4'b0000, 1'b0);
    step(1);
    check("basic_grant", outs_a(), 32'({4'b0100, 4'b0000, 1'b1, 1'b0}));
    step(2);
    check("basic_hold", 32'(ifa.gnt), 32'h4);
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);
    check("basic_release", outs_a(), 32'h0);
    drv_a(4'b1111, 4'b0000, 1'b0);
    step(1);
    check("ptr_after_2", 32'(ifa.gnt), 32'h8);
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);
    check("wrap_release", outs_a(), 32'h0);

    // Taint from non-winning request reaches the grant; pointer becomes tainted.
    drv_a(4'b0011, 4'b0010, 1'b0);
    step(1);
    check("taint_grant", outs_a(), 32'({4'b0001, 4'b1111, 1'b1, 1'b1}));
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);
    check("taint_release", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0000, 4'b1111}));
    step(1);
    check("idle_clean_gnt_t", 32'(ifa.gnt_t), 32'h0);
    drv_a(4'b0001, 4'b0000, 1'b0);
    step(1);
    check("sticky_ptr_t", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0001, 4'b1111}));
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);

    // Declassify on the same edge as a decision.
    drv_a(4'b0100, 4'b0000, 1'b1);
    step(1);
    check("declass_grant", outs_a(), 32'({4'b0100, 4'b0000, 1'b1, 1'b0}));
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);

    // Owner 1 picks up taint mid-tenure; taint_clr while busy has no effect.
    drv_a(4'b0010, 4'b0000, 1'b0);
    step(1);
    check("mid_grant_clean", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0010, 4'b0000}));
    drv_a(4'b0010, 4'b0010, 1'b0);
    step(1);
    check("mid_taint_in", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0010, 4'b1111}));
    drv_a(4'b0010, 4'b0000, 1'b1);
    step(1);
    check("mid_taint_sticky", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0010, 4'b1111}));
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);
    check("mid_release", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0000, 4'b1111}));
    drv_a(4'b0100, 4'b0000, 1'b0);
    step(1);
    check("mid_ptr_t_set", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0100, 4'b1111}));
    drv_a(4'b0000, 4'b0000, 1'b0);
    step(1);

    // Clean tenure on 0; non-owner requests/taints are ignored while busy.
    drv_a(4'b0001, 4'b0000, 1'b1);
    step(1);
    check("clr_grant_0", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0001, 4'b0000}));
    drv_a(4'b1001, 4'b1000, 1'b0);
    step(1);
    check("nonowner_ignored", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b0001, 4'b0000}));
    drv_a(4'b1000, 4'b0000, 1'b0);
    step(1);
    check("gap_idle", 32'({ifa.gnt, ifa.busy}), 32'h0);
    step(1);
    check("next_grant_3", 32'({ifa.gnt, ifa.gnt_t}), 32'({4'b1000, 4'b0000}));

    // Held request: exactly 16 cycles of grant, then forced release and regrant.
    for (int i = 1; i < 16; i++) begin
      step(1);
      check($sformatf("hold_%0d", i), 32'(ifa.gnt), 32'h8);
    end
    step(1);
    check("forced_release", 32'({ifa.gnt, ifa.busy}), 32'h0);
    step(1);
    check("regrant_only_req", 32'(ifa.gnt), 32'h8);

    // Taint the tenure, then reset asynchronously between edges.
    drv_a(4'b1000, 4'b1000, 1'b0);
    step(1);
    check("pre_reset", outs_a(), 32'({4'b1000, 4'b1111, 1'b1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs_a(), 32'h0);
    drv_a(4'b1001, 4'b0000, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("post_reset_grant", outs_a(), 32'({4'b0001, 4'b0000, 1'b1, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
